sharp_line_feeder: RTL and testbench
====================================

Name: sharp_line_feeder

Overview:
- Upstream stage of the LS013B7DH01 serial driver. It accepts pixel bytes on a valid/ready byte stream and packs them into 144-bit display lines.
- Each completed line is tagged with its 1-based gate line address (1..168) and handed to the driver over a valid/ready line interface.
- Double buffered (fill register plus output register), so byte intake continues while the driver shifts out the previous line.

Parameters:
- LINE_BITS, 144, pixels per line; must be a multiple of BYTE_W.
- NUM_LINES, 168, lines per frame; line address wraps after this value.
- BYTE_W, 8, input stream width.
- ADDR_W, 8, width of line_addr.

Ports:
- clk_12mhz  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_data  in  BYTE_W  pixel byte; 1 = white.
- s_sof  in  1  start-of-frame marker, qualified with s_valid; marks the first byte of line 1.
- s_valid  in  1  s_data/s_sof valid.
- s_ready  out  1  byte accepted on a cycle where s_valid && s_ready.
- line_data  out  LINE_BITS  packed line; bit 0 is the first pixel shifted out.
- line_addr  out  ADDR_W  gate line address, 1..NUM_LINES.
- line_valid  out  1  line_data/line_addr valid.
- line_ready  in  1  driver takes the line on line_valid && line_ready.
- frame_done  out  1  one-cycle pulse when line NUM_LINES is loaded into the output register.
- sof_err  out  1  sticky; set on a misaligned s_sof.

Behaviour:
- Reset: asynchronous, active-high; one clock (clk_12mhz).
  - Outputs at reset: line_data=0, line_addr=0, line_valid=0, frame_done=0, sof_err=0, s_ready=0 while rst is high.
  - Internal state at reset: byte index=0, line counter=1, fill_full=0.
  - s_ready goes to 1 on the first edge after rst deasserts.
  - Reset mid-operation discards the partial fill and any pending output line.
- Packing: byte k of a line (k=0..17) is written to fill bits [8k+7:8k]. Byte index increments on each accepted byte and returns to 0 after byte LINE_BITS/BYTE_W-1.
- Line completion, i.e. acceptance of the last byte:
  - If the output register is empty, or is being consumed this same cycle (line_valid && line_ready), the completed line (fill contents with the last byte merged) loads the output register on that edge. line_valid is 1 the next cycle.
  - Otherwise fill_full is set and s_ready=0 until the output register is consumed. The edge after consumption moves fill into output, then clears fill_full, and s_ready returns to 1.
  - Fill-to-output latency is 1 cycle after the last byte accepted (unstalled case).
- Line address:
  - The line counter value is captured into line_addr when the line enters the output register.
  - The counter then increments; after NUM_LINES it wraps to 1.
  - frame_done pulses in the same cycle line_valid rises for line_addr=NUM_LINES.
- Output handshake:
  - line_data and line_addr are held stable while line_valid && !line_ready.
  - line_valid drops the cycle after consumption unless a new line loads on that edge. Back-to-back lines are allowed.
- s_sof handling:
  - Accepted s_sof with byte index 0 and line counter 1: normal operation.
  - Otherwise: the partial fill is discarded, sof_err is set (sticky until rst), the line counter is forced to 1, and the sof byte becomes byte 0 of line 1.
  - A line already in the output register, or fill_full, is unaffected; the flush applies only to the partial fill.
  - s_sof on a cycle where s_ready=0 is ignored, since it is not accepted.
- Inputs are ignored when s_valid=0 or s_ready=0. No byte is ever dropped or duplicated.
- Size: NUM_LINES and LINE_BITS/BYTE_W are evaluated at elaboration; counters are sized with clog2.

Test Plan:
- After reset, send 18 bytes 0x00..0x11 with s_sof on byte 0 and line_ready=1. Required: line_valid high 1 cycle after byte 0x11 is accepted, line_data[7:0]=0x00, line_data[143:136]=0x11, line_addr=1, sof_err=0.
- Hold line_ready=0 and stream 36 bytes. Required: first line held with line_addr=1; second line fills; s_ready=0 after byte 36. Then pulse line_ready for 1 cycle. Required: line_addr=2 next cycle, s_ready=1 the cycle after.
- Stream a full frame of 168×18 bytes with line_ready=1. Required: line_addr sequence 1..168; frame_done a single pulse with line 168; next line gets addr 1.
- Send 5 bytes, then a byte with s_sof. Required: sof_err=1; the first line out is addr 1 with the sof byte at bits [7:0]; the earlier 5 bytes never appear.
- Assert rst mid-line while line_valid=1. Required: line_valid=0, s_ready=0 immediately. After release, the next 18 bytes produce line_addr=1.

Source files
------------

// File: rtl/sharp_line_feeder.sv
// Byte-stream to display-line packer for the LS013B7DH01 driver.
// A fill register collects bytes while an output register presents the previous line.
module sharp_line_feeder #(
  parameter int LINE_BITS = 144,
  parameter int NUM_LINES = 168,
  parameter int BYTE_W    = 8,
  parameter int ADDR_W    = 8
) (
  input  logic                 clk_12mhz,
  input  logic                 rst,
  input  logic [BYTE_W-1:0]    s_data,
  input  logic                 s_sof,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [LINE_BITS-1:0] line_data,
  output logic [ADDR_W-1:0]    line_addr,
  output logic                 line_valid,
  input  logic                 line_ready,
  output logic                 frame_done,
  output logic                 sof_err
);

  localparam int BYTES = LINE_BITS / BYTE_W;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CNT_W = $clog2(NUM_LINES + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_LINES);

  logic [IDX_W-1:0]     r_byte_idx;
  logic [CNT_W-1:0]     r_line_cnt;
  logic [LINE_BITS-1:0] r_fill;
  logic                 r_fill_full;
  logic                 r_s_ready;
  logic [LINE_BITS-1:0] r_line_data;
  logic [ADDR_W-1:0]    r_line_addr;
  logic                 r_line_valid;
  logic                 r_frame_done;
  logic                 r_sof_err;

  logic                 w_accept;
  logic                 w_consume;
  logic                 w_out_free;
  logic                 w_sof_flush;
  logic [IDX_W-1:0]     w_idx;
  logic                 w_last;
  logic                 w_drain;
  logic                 w_load;
  logic                 w_stall;
  logic                 w_fill_full_next;
  logic [CNT_W-1:0]     w_cnt_inc;
  logic [LINE_BITS-1:0] w_line;

  assign w_accept   = s_valid && r_s_ready;
  assign w_consume  = r_line_valid && line_ready;
  assign w_out_free = !r_line_valid || w_consume;

  // An accepted SOF always restarts at byte 0; it is only an error when misaligned.
  assign w_sof_flush = w_accept && s_sof && ((r_byte_idx != '0) || (r_line_cnt != CNT_ONE));
  assign w_idx       = (w_accept && s_sof) ? '0 : r_byte_idx;
  assign w_last      = w_accept && (w_idx == LAST_IDX);

  assign w_drain          = r_fill_full && w_out_free;
  assign w_load           = w_drain || (w_last && w_out_free);
  assign w_stall          = w_last && !w_out_free;
  assign w_fill_full_next = (r_fill_full && !w_drain) || w_stall;
  assign w_cnt_inc        = (r_line_cnt == CNT_MAX) ? CNT_ONE : r_line_cnt + CNT_ONE;

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_line = r_fill;
    w_line[w_idx*BYTE_W +: BYTE_W] = s_data;
  end

  // NOTE: the wide fill register carries no reset; byte index and fill_full decide when it is meaningful.
  always_ff @(posedge clk_12mhz) begin
    if (w_accept) r_fill <= w_line;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk_12mhz or posedge rst) begin
    if (rst) begin
      r_byte_idx   <= '0;
      r_line_cnt   <= CNT_ONE;
      r_fill_full  <= 1'b0;
      r_s_ready    <= 1'b0;
      r_line_data  <= '0;
      r_line_addr  <= '0;
      r_line_valid <= 1'b0;
      r_frame_done <= 1'b0;
      r_sof_err    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_fill_full  <= w_fill_full_next;
      // A drained stall keeps intake closed for one more cycle before reopening.
      r_s_ready    <= !w_fill_full_next && !w_drain;

      if (w_accept) r_byte_idx <= w_last ? '0 : w_idx + 1'b1;

      if (w_sof_flush) begin
        r_sof_err  <= 1'b1;
        r_line_cnt <= CNT_ONE;
      end

      if (w_load) begin
        r_line_data  <= w_drain ? r_fill : w_line;
        r_line_addr  <= ADDR_W'(r_line_cnt);
        r_line_cnt   <= w_cnt_inc;
        r_frame_done <= (r_line_cnt == CNT_MAX);
        r_line_valid <= 1'b1;
      end else if (w_consume) begin
        r_line_valid <= 1'b0;
      end
    end
  end

  assign s_ready    = r_s_ready;
  assign line_data  = r_line_data;
  assign line_addr  = r_line_addr;
  assign line_valid = r_line_valid;
  assign frame_done = r_frame_done;
  assign sof_err    = r_sof_err;

endmodule

// File: tb/tb_sharp_line_feeder.sv
// Directed bench for sharp_line_feeder: packing, stall, frame wrap, SOF recovery, reset.
module tb_sharp_line_feeder;

  localparam int LINE_BITS = 144;
  localparam int NUM_LINES = 168;
  localparam int BYTE_W    = 8;
  localparam int ADDR_W    = 8;
  localparam int BYTES     = LINE_BITS / BYTE_W;

  logic                 clk_12mhz = 1'b0;
  logic                 rst = 1'b1;
  logic [BYTE_W-1:0]    s_data = '0;
  logic                 s_sof = 1'b0;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic [LINE_BITS-1:0] line_data;
  logic [ADDR_W-1:0]    line_addr;
  logic                 line_valid;
  logic                 line_ready = 1'b0;
  logic                 frame_done;
  logic                 sof_err;

  int checks = 0;
  int errors = 0;

  sharp_line_feeder #(
    .LINE_BITS(LINE_BITS), .NUM_LINES(NUM_LINES), .BYTE_W(BYTE_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk_12mhz (clk_12mhz),
    .rst       (rst),
    .s_data    (s_data),
    .s_sof     (s_sof),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .line_data (line_data),
    .line_addr (line_addr),
    .line_valid(line_valid),
    .line_ready(line_ready),
    .frame_done(frame_done),
    .sof_err   (sof_err)
  );

  always #5 clk_12mhz = ~clk_12mhz;

  // Presents one byte and returns at posedge+1 of the edge that accepted it.
  task automatic send_byte(input logic [7:0] data, input logic sof);
    logic was_ready;
    bit   done;
    done    = 0;
    s_data  = data;
    s_sof   = sof;
    s_valid = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      was_ready = s_ready;
      @(posedge clk_12mhz);
      #1;
      if (was_ready) done = 1;
    end
    s_valid = 1'b0;
    s_sof   = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout: byte %0h not accepted within 50 cycles, required acceptance", data);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    s_sof = 1'b0;
    repeat (2) @(posedge clk_12mhz);
    #1;
    rst = 1'b0;
    @(posedge clk_12mhz);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    line_ready = 1'b0;
    repeat (2) @(posedge clk_12mhz);
    #1;
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
    checks++;
    if ({line_valid, frame_done, sof_err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got v/fd/err=%b want 000", {line_valid, frame_done, sof_err});
    end
    checks++;
    if (line_data !== '0 || line_addr !== '0) begin
      errors++; $display("FAIL reset_data: got addr %0d data %h want 0/0", line_addr, line_data);
    end
    rst = 1'b0;
    @(posedge clk_12mhz);
    #1;
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", s_ready); end
  endtask

  task automatic test_first_line();
    logic [LINE_BITS-1:0] exp;
    line_ready = 1'b1;
    for (int k = 0; k < BYTES; k++) begin
      exp[k*8 +: 8] = 8'(k);
      send_byte(8'(k), k == 0);
      if (k == BYTES - 2) begin
        checks++;
        if (line_valid !== 1'b0) begin errors++; $display("FAIL first_line_early: line_valid %b want 0", line_valid); end
      end
    end
    checks++;
    if (line_valid !== 1'b1) begin errors++; $display("FAIL first_line_valid: got %b want 1", line_valid); end
    checks++;
    if (line_data[7:0] !== 8'h00 || line_data[143:136] !== 8'h11) begin
      errors++; $display("FAIL first_line_ends: got %h/%h want 00/11", line_data[7:0], line_data[143:136]);
    end
    checks++;
    if (line_data !== exp) begin errors++; $display("FAIL first_line_data: got %h want %h", line_data, exp); end
    checks++;
    if (line_addr !== 8'd1 || sof_err !== 1'b0) begin
      errors++; $display("FAIL first_line_addr: got addr %0d err %b want 1/0", line_addr, sof_err);
    end
    @(posedge clk_12mhz);
    #1;
    checks++;
    if (line_valid !== 1'b0) begin errors++; $display("FAIL first_line_consumed: line_valid %b want 0", line_valid); end
  endtask

  task automatic test_stall();
    logic [LINE_BITS-1:0] exp_a, exp_b;
    do_reset();
    line_ready = 1'b0;
    for (int k = 0; k < 2 * BYTES; k++) begin
      if (k < BYTES) exp_a[k*8 +: 8] = 8'(8'h40 + k);
      else           exp_b[(k-BYTES)*8 +: 8] = 8'(8'h40 + k);
      send_byte(8'(8'h40 + k), k == 0);
    end
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b want 0", s_ready); end
    checks++;
    if (line_valid !== 1'b1 || line_addr !== 8'd1 || line_data !== exp_a) begin
      errors++; $display("FAIL stall_hold: got v %b addr %0d data %h want 1/1/%h", line_valid, line_addr, line_data, exp_a);
    end
    // SOF offered while intake is closed must be ignored.
    s_valid = 1'b1; s_sof = 1'b1; s_data = 8'hEE;
    repeat (3) @(posedge clk_12mhz);
    #1;
    s_valid = 1'b0; s_sof = 1'b0;
    checks++;
    if (sof_err !== 1'b0 || line_addr !== 8'd1) begin
      errors++; $display("FAIL stall_sof_ignored: got err %b addr %0d want 0/1", sof_err, line_addr);
    end
    line_ready = 1'b1;
    @(posedge clk_12mhz);
    #1;
    line_ready = 1'b0;
    checks++;
    if (line_valid !== 1'b1 || line_addr !== 8'd2 || line_data !== exp_b) begin
      errors++; $display("FAIL stall_second_line: got v %b addr %0d data %h want 1/2/%h", line_valid, line_addr, line_data, exp_b);
    end
    @(posedge clk_12mhz);
    #1;
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_return: got %b want 1", s_ready); end
    line_ready = 1'b1;
    @(posedge clk_12mhz);
    #1;
  endtask

  task automatic test_full_frame();
    int pulses;
    int addr_errs;
    pulses = 0;
    addr_errs = 0;
    do_reset();
    line_ready = 1'b1;
    for (int l = 1; l <= NUM_LINES; l++) begin
      for (int k = 0; k < BYTES; k++) begin
        send_byte(8'(l + k), (l == 1) && (k == 0));
        if (frame_done === 1'b1) pulses++;
      end
      checks++;
      if (line_valid !== 1'b1 || line_addr !== 8'(l) || frame_done !== (l == NUM_LINES)) begin
        errors++; addr_errs++;
        if (addr_errs < 5)
          $display("FAIL frame_line_%0d: got v %b addr %0d fd %b want 1/%0d/%b", l, line_valid, line_addr, frame_done, l, l == NUM_LINES);
      end
    end
    for (int k = 0; k < BYTES; k++) begin
      send_byte(8'(k), 1'b0);
      if (frame_done === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL frame_done_pulses: got %0d want 1", pulses); end
    checks++;
    if (line_addr !== 8'd1 || frame_done !== 1'b0) begin
      errors++; $display("FAIL frame_wrap: got addr %0d fd %b want 1/0", line_addr, frame_done);
    end
    checks++;
    if (sof_err !== 1'b0) begin errors++; $display("FAIL frame_sof_err: got %b want 0", sof_err); end
  endtask

  task automatic test_sof_realign();
    logic [LINE_BITS-1:0] exp;
    do_reset();
    line_ready = 1'b1;
    for (int k = 0; k < 5; k++) send_byte(8'(8'hE0 + k), 1'b0);
    checks++;
    if (line_valid !== 1'b0) begin errors++; $display("FAIL sof_partial_out: line_valid %b want 0", line_valid); end
    exp[7:0] = 8'hA5;
    send_byte(8'hA5, 1'b1);
    checks++;
    if (sof_err !== 1'b1) begin errors++; $display("FAIL sof_err_set: got %b want 1", sof_err); end
    for (int k = 1; k < BYTES; k++) begin
      exp[k*8 +: 8] = 8'(8'hB0 + k);
      send_byte(8'(8'hB0 + k), 1'b0);
    end
    checks++;
    if (line_valid !== 1'b1 || line_addr !== 8'd1 || line_data !== exp) begin
      errors++; $display("FAIL sof_line: got v %b addr %0d data %h want 1/1/%h", line_valid, line_addr, line_data, exp);
    end
    repeat (3) @(posedge clk_12mhz);
    #1;
    checks++;
    if (sof_err !== 1'b1) begin errors++; $display("FAIL sof_err_sticky: got %b want 1", sof_err); end
  endtask

  task automatic test_reset_mid_line();
    logic [LINE_BITS-1:0] exp;
    do_reset();
    line_ready = 1'b0;
    for (int k = 0; k < BYTES; k++) send_byte(8'(8'h80 + k), k == 0);
    for (int k = 0; k < 5; k++) send_byte(8'(8'h90 + k), 1'b0);
    checks++;
    if (line_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid: got %b want 1", line_valid); end
    rst = 1'b1;
    #1;
    checks++;
    if (line_valid !== 1'b0 || s_ready !== 1'b0) begin
      errors++; $display("FAIL midrst_async: got v %b rdy %b want 0/0", line_valid, s_ready);
    end
    checks++;
    if (line_addr !== '0 || line_data !== '0) begin
      errors++; $display("FAIL midrst_clear: got addr %0d data %h want 0/0", line_addr, line_data);
    end
    @(posedge clk_12mhz);
    #1;
    rst = 1'b0;
    @(posedge clk_12mhz);
    #1;
    checks++;
    if (s_ready !== 1'b1 || line_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_release: got rdy %b v %b want 1/0", s_ready, line_valid);
    end
    line_ready = 1'b1;
    for (int k = 0; k < BYTES; k++) begin
      exp[k*8 +: 8] = 8'(8'hC0 + k);
      send_byte(8'(8'hC0 + k), 1'b0);
    end
    checks++;
    if (line_valid !== 1'b1 || line_addr !== 8'd1 || line_data !== exp) begin
      errors++; $display("FAIL midrst_line: got v %b addr %0d data %h want 1/1/%h", line_valid, line_addr, line_data, exp);
    end
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_stall();
    test_full_frame();
    test_sof_realign();
    test_reset_mid_line();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
